dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/debug arbiter in front of the single data_memory port.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking (default: CPU priority).
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              WE_dmem,
  output logic [ADDR_W-1:0] alu_out,
  output logic [DATA_W-1:0] reg_out,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state;
  logic   win_dbg;
  logic   pick_dbg;

`ifdef DMEM_ARB_RR_EN
  logic last_dbg;

  // on a tie, grant whichever port was not granted last
  always_comb begin
    pick_dbg = 1'b0;
    unique case (1'b1)
      (cpu_req && dbg_req):  pick_dbg = !last_dbg;
      (!cpu_req && dbg_req): pick_dbg = 1'b1;
      default:               pick_dbg = 1'b0;
    endcase
  end

  // last-grant pointer; starts at debug so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg <= 1'b1;
    end else if (state == IDLE && (cpu_req || dbg_req)) begin
      last_dbg <= pick_dbg;
    end
  end
`else
  // CPU always wins a tie
  always_comb begin
    pick_dbg = !cpu_req && dbg_req;
  end
`endif

  // grant, hold the memory port for one cycle, then pulse the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_dbg   <= 1'b0;
      WE_dmem   <= 1'b0;
      alu_out   <= '0;
      reg_out   <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            win_dbg <= pick_dbg;
            WE_dmem <= pick_dbg ? dbg_we : cpu_we;
            alu_out <= pick_dbg ? dbg_addr : cpu_addr;
            reg_out <= pick_dbg ? dbg_wdata : cpu_wdata;
            busy    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!WE_dmem) begin
            if (win_dbg) dbg_rdata <= mem_out;
            else         cpu_rdata <= mem_out;
          end
          WE_dmem <= 1'b0;
          cpu_ack <= !win_dbg;
          dbg_ack <= win_dbg;
          state   <= DONE;
        end
        DONE: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a data_memory model.
// Expected ack order/rdata are queued at issue; a negedge monitor checks them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        WE_dmem, busy;
  logic [15:0] alu_out, reg_out, mem_out;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .WE_dmem(WE_dmem), .alu_out(alu_out),
    .reg_out(reg_out), .mem_out(mem_out),
    .busy(busy)
  );

  logic [15:0] mem [65536];
  assign mem_out = mem[alu_out];

  // data_memory: synchronous write, combinational read
  always @(posedge clk) begin
    if (WE_dmem) mem[alu_out] <= reg_out;
  end

  typedef struct {
    logic        port;
    logic [15:0] rd;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
  } tx_t;

  exp_t exp_q[$];
  tx_t  cq[$];
  tx_t  dq[$];
  int   total = 0;
  int   bad = 0;
  int   acks = 0;
  int   we_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void exp_push(input logic p, input logic [15:0] r);
    exp_t e;
    e.port = p;
    e.rd = r;
    exp_q.push_back(e);
  endfunction

  // monitor: every ack pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (WE_dmem) we_cycles++;
    if (cpu_ack || dbg_ack) begin
      acks++;
      chk("ack_onehot", 32'(cpu_ack) + 32'(dbg_ack), 1);
      chk("ack_busy", busy, 1);
      chk("exp_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ack_port", dbg_ack, e.port);
        chk(e.port ? "dbg_rdata" : "cpu_rdata",
            e.port ? dbg_rdata : cpu_rdata, e.rd);
      end
    end
  end

  task automatic set_port(input logic p, input logic r, input logic we,
                          input logic [15:0] a, input logic [15:0] d);
    if (p) begin
      dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic idle_sync();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input logic p);
    int   n = 0;
    logic a = 1'b0;
    while (!a && n < 20) begin
      @(posedge clk);
      #2;
      n++;
      a = p ? dbg_ack : cpu_ack;
    end
    chk("ack_seen", a, 1);
  endtask

  task automatic acc(input logic p, input logic we, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] rd);
    exp_push(p, rd);
    set_port(p, 1'b1, we, a, d);
    wait_ack(p);
    set_port(p, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // keeps each port's request up back-to-back until its queue drains
  task automatic serve();
    int n = 0;
    if (cq.size() > 0) set_port(0, 1, cq[0].we, cq[0].a, cq[0].d);
    if (dq.size() > 0) set_port(1, 1, dq[0].we, dq[0].a, dq[0].d);
    while ((cq.size() > 0 || dq.size() > 0) && n < 60) begin
      @(posedge clk);
      #2;
      n++;
      if (cpu_ack && cq.size() > 0) begin
        void'(cq.pop_front());
        if (cq.size() > 0) set_port(0, 1, cq[0].we, cq[0].a, cq[0].d);
        else               set_port(0, 0, 0, 16'h0, 16'h0);
      end
      if (dbg_ack && dq.size() > 0) begin
        void'(dq.pop_front());
        if (dq.size() > 0) set_port(1, 1, dq[0].we, dq[0].a, dq[0].d);
        else               set_port(1, 0, 0, 16'h0, 16'h0);
      end
    end
    chk("serve_done", cq.size() + dq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_t t;
    int  a0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    set_port(0, 0, 0, 16'h0, 16'h0);
    set_port(1, 0, 0, 16'h0, 16'h0);

    // reset values
    @(negedge clk);
    chk("rst_we", WE_dmem, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_reg_out", reg_out, 0);
    chk("rst_acks", {cpu_ack, dbg_ack}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle_sync();

    // cpu write 0x0567 -> 0x0000, latency and WE window
    exp_push(0, 16'h0000);
    set_port(0, 1, 1, 16'h0000, 16'h0567);
    @(negedge clk);
    chk("lat_idle_we", WE_dmem, 0);
    @(negedge clk);
    chk("lat_access_we", WE_dmem, 1);
    chk("lat_access_addr", alu_out, 16'h0000);
    chk("lat_access_data", reg_out, 16'h0567);
    chk("lat_access_busy", busy, 1);
    chk("lat_access_ack", cpu_ack, 0);
    @(negedge clk);
    chk("lat_done_ack", cpu_ack, 1);
    chk("lat_done_we", WE_dmem, 0);
    idle_sync();
    set_port(0, 0, 0, 16'h0, 16'h0);
    chk("mem_0000", mem[16'h0000], 16'h0567);

    // dbg read after cpu write, no write strobe during the read
    acc(0, 1, 16'h00F2, 16'h0345, 16'h0000);
    a0 = we_cycles;
    acc(1, 0, 16'h00F2, 16'h0000, 16'h0345);
    chk("dbg_rd_no_we", we_cycles - a0, 0);

    // rdata holds across a write
    acc(0, 0, 16'h00F2, 16'h0000, 16'h0345);
    acc(0, 1, 16'h0010, 16'h1111, 16'h0345);

    // top address, no wrap
    acc(0, 1, 16'hFFFF, 16'h89A4, 16'h0345);
    acc(0, 0, 16'hFFFF, 16'h0000, 16'h89A4);
    chk("mem_fffe", mem[16'hFFFE], 16'h0000);
    chk("mem_0000_kept", mem[16'h0000], 16'h0567);
    chk("mem_00f2_kept", mem[16'h00F2], 16'h0345);
    chk("mem_0010", mem[16'h0010], 16'h1111);

    // request dropped during ACCESS still completes
    idle_sync();
    exp_push(0, 16'h89A4);
    set_port(0, 1, 1, 16'h0020, 16'h2222);
    @(negedge clk);
    @(negedge clk);
    chk("drop_access_busy", busy, 1);
    set_port(0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("drop_ack", cpu_ack, 1);
    @(negedge clk);
    chk("drop_ack_once", cpu_ack, 0);
    chk("drop_idle", busy, 0);
    chk("mem_0020", mem[16'h0020], 16'h2222);

    // reset during ACCESS abandons the write
    idle_sync();
    set_port(0, 1, 1, 16'h0100, 16'hDEAD);
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_we", WE_dmem, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", WE_dmem, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", alu_out, 0);
    set_port(0, 0, 0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a0 = acks;
    repeat (6) @(negedge clk);
    chk("arst_no_ack", acks - a0, 0);
    chk("mem_0100", mem[16'h0100], 16'h0000);
    idle_sync();
    acc(0, 0, 16'h0000, 16'h0000, 16'h0567);

    // simultaneous requests, fresh reset so the tie pointer is known
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_sync();
    for (int i = 0; i < 4; i++) begin
      t.we = 1'b1;
      t.a = 16'h0200 + 16'(i);
      t.d = 16'h1000 + 16'(i);
      cq.push_back(t);
    end
    for (int i = 0; i < 2; i++) begin
      t.we = 1'b0;
      t.a = 16'h0200 + 16'(i);
      t.d = 16'h0000;
      dq.push_back(t);
    end
`ifdef DMEM_ARB_RR_EN
    exp_push(0, 16'h0000);
    exp_push(1, 16'h1000);
    exp_push(0, 16'h0000);
    exp_push(1, 16'h1001);
    exp_push(0, 16'h0000);
    exp_push(0, 16'h0000);
`else
    exp_push(0, 16'h0000);
    exp_push(0, 16'h0000);
    exp_push(0, 16'h0000);
    exp_push(0, 16'h0000);
    exp_push(1, 16'h1000);
    exp_push(1, 16'h1001);
`endif
    serve();
    chk("mem_0203", mem[16'h0203], 16'h1003);

    repeat (4) @(negedge clk);
    chk("exp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
